wb_regfile: RTL

WB_REGFILE -- requirements
Module: wb_regfile

---
 rtl/wb_regfile_if.sv | 33 +++
 rtl/wb_regfile.sv | 79 +++++++
 2 files changed

// File: rtl/wb_regfile_if.sv
// wb_regfile_if: bundles the MEM/WB write-back inputs, the two decode-stage
// read ports and the write-back status outputs of wb_regfile.
//   master : pipeline side, drives write-back controls/data and read indices
//   slave  : register file side, returns read data, wb_data/wb_valid, count
interface wb_regfile_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
);
  logic              RegWrite_i;
  logic              MemtoReg_i;
  logic [DATA_W-1:0] alu_result_i;
  logic [DATA_W-1:0] read_data_i;
  logic [ADDR_W-1:0] write_addr_i;
  logic [ADDR_W-1:0] rs_addr_i;
  logic [ADDR_W-1:0] rt_addr_i;
  logic [DATA_W-1:0] rs_data_o;
  logic [DATA_W-1:0] rt_data_o;
  logic [DATA_W-1:0] wb_data_o;
  logic              wb_valid_o;
  logic [31:0]       wb_count_o;

  modport master (
    output RegWrite_i, MemtoReg_i, alu_result_i, read_data_i,
    output write_addr_i, rs_addr_i, rt_addr_i,
    input  rs_data_o, rt_data_o, wb_data_o, wb_valid_o, wb_count_o
  );

  modport slave (
    input  RegWrite_i, MemtoReg_i, alu_result_i, read_data_i,
    input  write_addr_i, rs_addr_i, rt_addr_i,
    output rs_data_o, rt_data_o, wb_data_o, wb_valid_o, wb_count_o
  );
endinterface

// File: rtl/wb_regfile.sv
// wb_regfile: 2**ADDR_W x DATA_W register file with MEM/WB write-back mux,
// two combinational read ports with write-through bypass, register 0 hard-wired
// to zero, and a wrapping count of committed writes.
// Ports:
//   clk    : clock, all state updates on the rising edge
//   rst_n  : synchronous active-low reset (clears registers and count)
//   bus_io : wb_regfile_if slave modport (write-back inputs, read ports,
//            wb_data_o / wb_valid_o / wb_count_o)
module wb_regfile #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input logic         clk,
  input logic         rst_n,
  wb_regfile_if.slave bus_io
);

  localparam int unsigned NumRegs = 2 ** ADDR_W;

  logic [DATA_W-1:0] regs_q [NumRegs];
  logic [DATA_W-1:0] regs_d [NumRegs];
  logic [31:0]       wb_count_q, wb_count_d;

  logic [DATA_W-1:0] wb_data;
  logic              wb_valid;

  // Write-back source select is independent of RegWrite_i so EX forwarding
  // always sees the candidate value.
  assign wb_data  = bus_io.MemtoReg_i ? bus_io.read_data_i : bus_io.alu_result_i;
  assign wb_valid = bus_io.RegWrite_i && (bus_io.write_addr_i != '0);

  assign bus_io.wb_data_o  = wb_data;
  assign bus_io.wb_valid_o = wb_valid;
  assign bus_io.wb_count_o = wb_count_q;

  // Read port A: index 0 is constant zero; a write committing this cycle to
  // the same index is forwarded instead of the stale stored value.
  always_comb begin
    bus_io.rs_data_o = regs_q[bus_io.rs_addr_i];
    if (bus_io.rs_addr_i == '0) begin
      bus_io.rs_data_o = '0;
    end else if (wb_valid && (bus_io.rs_addr_i == bus_io.write_addr_i)) begin
      bus_io.rs_data_o = wb_data;
    end
  end

  // Read port B: same rules, bypassed independently of port A.
  always_comb begin
    bus_io.rt_data_o = regs_q[bus_io.rt_addr_i];
    if (bus_io.rt_addr_i == '0) begin
      bus_io.rt_data_o = '0;
    end else if (wb_valid && (bus_io.rt_addr_i == bus_io.write_addr_i)) begin
      bus_io.rt_data_o = wb_data;
    end
  end

  always_comb begin
    regs_d     = regs_q;
    wb_count_d = wb_count_q;
    if (wb_valid) begin
      regs_d[bus_io.write_addr_i] = wb_data;
      wb_count_d                  = wb_count_q + 32'd1;  // wraps naturally
    end
  end

  // Reset wins over a simultaneous write; the write is neither stored nor counted.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NumRegs; i++) begin
        regs_q[i] <= '0;
      end
      wb_count_q <= '0;
    end else begin
      regs_q     <= regs_d;
      wb_count_q <= wb_count_d;
    end
  end

endmodule
